// File: rtl/alu_lifo_pkg.sv
// Shared definitions for the ALU/LIFO block and its clients.
// Holds the 4-bit ALU op-code constants.
package alu_lifo_pkg;

    typedef logic [3:0] op_t;

    localparam op_t NO_OP  = 4'd0;
    localparam op_t ADD_OP = 4'd1;
    localparam op_t SUB_OP = 4'd2;
    localparam op_t AND_OP = 4'd3;
    localparam op_t OR_OP  = 4'd4;
    localparam op_t XOR_OP = 4'd5;
    localparam op_t ROL_OP = 4'd6;
    localparam op_t ROR_OP = 4'd7;

endpackage

// File: rtl/alu_lifo_if.sv
// Bundles the ALU operand/result signals and the stack push/pop signals.
// The slave modport is the alu_lifo side; the master modport is the client side.
interface alu_lifo_if #(
    parameter int unsigned WIDTH = 16
);
    import alu_lifo_pkg::*;

    op_t              i_op;
    logic [WIDTH-1:0] i_arg0;
    logic [WIDTH-1:0] i_arg1;
    logic [WIDTH-1:0] o_data;
    logic [WIDTH-1:0] i_data;
    logic             i_push;
    logic             i_pop;
    logic [WIDTH-1:0] o_s0;
    logic [WIDTH-1:0] o_s1;

    modport slave (
        input  i_op, i_arg0, i_arg1, i_data, i_push, i_pop,
        output o_data, o_s0, o_s1
    );

    modport master (
        output i_op, i_arg0, i_arg1, i_data, i_push, i_pop,
        input  o_data, o_s0, o_s1
    );

endinterface

// File: rtl/lifo_stack.sv
// Shift-register LIFO: cell 0 is the top; overflow drops the bottom cell and
// underflow shifts in zeros, both silently.
module lifo_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_s0,
    output logic [WIDTH-1:0] o_s1
);

    logic [DEPTH-1:0][WIDTH-1:0] cells_q, cells_d;

    always_comb begin
        cells_d = cells_q;
        if (i_push && i_pop) begin
            // Simultaneous push and pop replaces the top in place.
            cells_d[0] = i_data;
        end else if (i_push) begin
            cells_d[0] = i_data;
            for (int k = 1; k < int'(DEPTH); k++) begin
                cells_d[k] = cells_q[k-1];
            end
        end else if (i_pop) begin
            for (int k = 0; k < int'(DEPTH) - 1; k++) begin
                cells_d[k] = cells_q[k+1];
            end
            cells_d[DEPTH-1] = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cells_q <= '0;
        end else begin
            cells_q <= cells_d;
        end
    end

    assign o_s0 = cells_q[0];
    assign o_s1 = cells_q[1];

endmodule

// File: rtl/alu_lifo.sv
// Registered single-cycle ALU alongside an independent shift-register stack.
// The two datapaths share only clock and reset.
module alu_lifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    alu_lifo_if.slave   bus
);
    import alu_lifo_pkg::*;

    logic [WIDTH-1:0] data_q, data_d;

    // Add/sub wrap modulo 2^WIDTH; unused codes yield zero.
    always_comb begin
        data_d = '0;
        case (bus.i_op)
            NO_OP:   data_d = bus.i_arg0;
            ADD_OP:  data_d = bus.i_arg0 + bus.i_arg1;
            SUB_OP:  data_d = bus.i_arg0 - bus.i_arg1;
            AND_OP:  data_d = bus.i_arg0 & bus.i_arg1;
            OR_OP:   data_d = bus.i_arg0 | bus.i_arg1;
            XOR_OP:  data_d = bus.i_arg0 ^ bus.i_arg1;
            ROL_OP:  data_d = {bus.i_arg0[WIDTH-2:0], bus.i_arg0[WIDTH-1]};
            ROR_OP:  data_d = {bus.i_arg0[0], bus.i_arg0[WIDTH-1:1]};
            default: data_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign bus.o_data = data_q;

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (bus.i_push),
        .i_pop  (bus.i_pop),
        .i_data (bus.i_data),
        .o_s0   (bus.o_s0),
        .o_s1   (bus.o_s1)
    );

endmodule

// File: tb/tb_alu_lifo.sv
// Self-checking bench for alu_lifo: queue/arithmetic reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_alu_lifo;
    import alu_lifo_pkg::*;

    localparam int W = 16;
    localparam int D = 12;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    alu_lifo_if #(.WIDTH(W)) bus ();

    alu_lifo #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stack is a queue whose front is the top of stack.
    logic [W-1:0] m_data;
    logic [W-1:0] m_stk[$];

    function automatic logic [W-1:0] alu_ref(input op_t op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            4'd0:    r = a;
            4'd1:    r = W'((32'(a) + 32'(b)) % (32'd1 << W));
            4'd2:    r = W'((32'(a) + (32'd1 << W) - 32'(b)) % (32'd1 << W));
            4'd3:    r = a & b;
            4'd4:    r = a | b;
            4'd5:    r = a ^ b;
            4'd6:    r = W'(32'(a) * 2 + 32'(a) / (32'd1 << (W - 1)));
            4'd7:    r = W'((32'(a) % 2) * (32'd1 << (W - 1)) + 32'(a) / 2);
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_data = '0;
            m_stk.delete();
        end else begin
            m_data = alu_ref(bus.i_op, bus.i_arg0, bus.i_arg1);
            if (bus.i_push && bus.i_pop) begin
                if (m_stk.size() > 0) m_stk[0] = bus.i_data;
                else m_stk.push_front(bus.i_data);
            end else if (bus.i_push) begin
                m_stk.push_front(bus.i_data);
                if (m_stk.size() > D) void'(m_stk.pop_back());
            end else if (bus.i_pop) begin
                if (m_stk.size() > 0) void'(m_stk.pop_front());
            end
        end
    end

    // Compare process: checks every cycle outside reset.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            chk("model o_data", bus.o_data, m_data);
            chk("model o_s0", bus.o_s0, (m_stk.size() > 0) ? m_stk[0] : '0);
            chk("model o_s1", bus.o_s1, (m_stk.size() > 1) ? m_stk[1] : '0);
        end
    end

    task automatic step(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic push, input logic pop, input logic [W-1:0] d);
        bus.i_op   = op;
        bus.i_arg0 = a;
        bus.i_arg1 = b;
        bus.i_push = push;
        bus.i_pop  = pop;
        bus.i_data = d;
        @(posedge i_clk);
        #2;
    endtask

    task automatic alu(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        step(op, a, b, 1'b0, 1'b0, '0);
    endtask

    task automatic stk(input logic push, input logic pop, input logic [W-1:0] d);
        step(NO_OP, '0, '0, push, pop, d);
    endtask

    initial begin
        bus.i_op = NO_OP; bus.i_arg0 = '0; bus.i_arg1 = '0;
        bus.i_push = 1'b0; bus.i_pop = 1'b0; bus.i_data = '0;

        #2;
        chk("reset o_data", bus.o_data, 16'h0000);
        chk("reset o_s0", bus.o_s0, 16'h0000);
        chk("reset o_s1", bus.o_s1, 16'h0000);
        #10 i_rst = 1'b0;

        // ALU directed vectors, one cycle latency.
        alu(ADD_OP, 16'hFFFF, 16'h0001); chk("add wrap", bus.o_data, 16'h0000);
        alu(SUB_OP, 16'h0000, 16'h0001); chk("sub borrow", bus.o_data, 16'hFFFF);
        alu(XOR_OP, 16'hFFFF, 16'h1234); chk("xor", bus.o_data, 16'hEDCB);
        alu(NO_OP, 16'hBEEF, 16'h1234);  chk("no_op", bus.o_data, 16'hBEEF);
        alu(ROL_OP, 16'h8001, 16'hFFFF); chk("rol", bus.o_data, 16'h0003);
        alu(ROR_OP, 16'h8001, 16'hFFFF); chk("ror", bus.o_data, 16'hC000);
        alu(4'd9, 16'h1234, 16'h5678);   chk("code 9", bus.o_data, 16'h0000);
        alu(AND_OP, 16'hF0F0, 16'h3C3C); chk("and", bus.o_data, 16'h3030);
        alu(OR_OP, 16'hF0F0, 16'h0F01);  chk("or", bus.o_data, 16'hFFF1);
        alu(4'd15, 16'hFFFF, 16'hFFFF);  chk("code 15", bus.o_data, 16'h0000);

        // Stack ordering and underflow.
        stk(1'b1, 1'b0, 16'h0001);
        stk(1'b1, 1'b0, 16'h0002);
        stk(1'b1, 1'b0, 16'h0003);
        chk("push3 s0", bus.o_s0, 16'h0003); chk("push3 s1", bus.o_s1, 16'h0002);
        stk(1'b0, 1'b1, '0);
        chk("pop1 s0", bus.o_s0, 16'h0002); chk("pop1 s1", bus.o_s1, 16'h0001);
        stk(1'b0, 1'b1, '0);
        stk(1'b0, 1'b1, '0);
        chk("empty s0", bus.o_s0, 16'h0000); chk("empty s1", bus.o_s1, 16'h0000);
        stk(1'b0, 1'b1, '0);
        chk("underflow s0", bus.o_s0, 16'h0000); chk("underflow s1", bus.o_s1, 16'h0000);

        // Replace top with simultaneous push and pop.
        stk(1'b1, 1'b0, 16'h000B);
        stk(1'b1, 1'b0, 16'h000A);
        stk(1'b1, 1'b1, 16'h00FF);
        chk("replace s0", bus.o_s0, 16'h00FF); chk("replace s1", bus.o_s1, 16'h000B);
        stk(1'b0, 1'b1, '0);
        stk(1'b0, 1'b1, '0);
        chk("drained s0", bus.o_s0, 16'h0000);

        // Overflow: value 1 falls off the bottom.
        for (int i = 1; i <= D + 1; i++) stk(1'b1, 1'b0, W'(i));
        chk("overflow top", bus.o_s0, 16'd13);
        for (int i = 1; i <= D; i++) begin
            stk(1'b0, 1'b1, '0);
            chk("overflow pop", bus.o_s0, (i <= D - 1) ? W'(13 - i) : '0);
        end

        // ALU and stack together in one cycle.
        step(ADD_OP, 16'h1000, 16'h0234, 1'b1, 1'b0, 16'h00AA);
        chk("both alu", bus.o_data, 16'h1234); chk("both s0", bus.o_s0, 16'h00AA);
        stk(1'b0, 1'b1, '0);

        // Asynchronous reset mid-run.
        step(ADD_OP, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h1111);
        step(ADD_OP, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h2222);
        chk("pre-rst s0", bus.o_s0, 16'h2222); chk("pre-rst o_data", bus.o_data, 16'h0002);
        i_rst = 1'b1;
        #1;
        chk("async rst o_data", bus.o_data, 16'h0000);
        chk("async rst s0", bus.o_s0, 16'h0000);
        chk("async rst s1", bus.o_s1, 16'h0000);
        step(XOR_OP, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h3333);
        chk("rst hold o_data", bus.o_data, 16'h0000);
        chk("rst hold s0", bus.o_s0, 16'h0000);
        #1 i_rst = 1'b0;
        step(NO_OP, 16'h4242, '0, 1'b1, 1'b0, 16'h0055);
        chk("post-rst s0", bus.o_s0, 16'h0055); chk("post-rst s1", bus.o_s1, 16'h0000);
        chk("post-rst o_data", bus.o_data, 16'h4242);

        @(negedge i_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_lifo.md
ALU_LIFO -- requirements
Module: alu_lifo

Interface
REQ-001 Parameter WIDTH, default 16, bits per data word for ALU and stack.
REQ-002 Parameter DEPTH, default 12, number of stack cells, minimum 2.
REQ-003 i_clk  input  1  system clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_op  input  4  ALU operation code.
REQ-006 i_arg0  input  WIDTH  ALU first operand.
REQ-007 i_arg1  input  WIDTH  ALU second operand.
REQ-008 o_data  output  WIDTH  registered ALU result.
REQ-009 i_data  input  WIDTH  value to push onto the stack.
REQ-010 i_push  input  1  push request.
REQ-011 i_pop  input  1  pop request.
REQ-012 o_s0  output  WIDTH  top-of-stack value.
REQ-013 o_s1  output  WIDTH  second-of-stack value.

Function
REQ-014 ALU and stack SHALL be independent datapaths sharing only i_clk/i_rst.
REQ-015 o_data SHALL update every rising edge from the i_op/i_arg0/i_arg1 sampled at that edge; latency exactly 1 cycle.
REQ-016 Op codes: 0 NO_OP -> arg0 (pass-through); 1 ADD -> arg0+arg1; 2 SUB -> arg0-arg1; 3 AND; 4 OR; 5 XOR; 6 ROL -> {arg0[WIDTH-2:0],arg0[WIDTH-1]}; 7 ROR -> {arg0[0],arg0[WIDTH-1:1]}.
REQ-017 ADD/SUB SHALL be modulo 2^WIDTH; carry/borrow discarded, no flags.
REQ-018 ROL/ROR SHALL ignore arg1.
REQ-019 Codes 8-15 SHALL produce 0.
REQ-020 Stack SHALL be a shift-register of DEPTH cells; o_s0 = cell 0, o_s1 = cell 1, both driven directly from registers (valid the cycle after the edge, no read latency).
REQ-021 Push only: cell0 <= i_data, cell k <= cell k-1; bottom cell value lost (no full flag, no error).
REQ-022 Pop only: cell k <= cell k+1; bottom cell <= 0.
REQ-023 Push and pop same cycle: cell0 <= i_data, other cells unchanged (replace top).
REQ-024 Neither: cells hold.
REQ-025 Pop on empty (all zero) SHALL keep all cells 0; no underflow indication.
REQ-026 No count, full or empty outputs; underflow/overflow are silent.

Reset
REQ-027 i_rst high SHALL asynchronously clear o_data and all stack cells to 0 (o_s0=o_s1=0).
REQ-028 While i_rst high, i_push/i_pop/i_op SHALL be ignored.
REQ-029 First operation SHALL take effect on the first rising edge after i_rst deasserts.
REQ-030 Reset mid-operation SHALL discard any in-flight ALU result and all stack contents.

Structure
REQ-031 A shared package SHALL hold the 4-bit op-code constants (NO_OP, ADD_OP, SUB_OP, AND_OP, OR_OP, XOR_OP, ROL_OP, ROR_OP) for use by the block and its clients.
REQ-032 The stack SHALL be one sub-module, lifo_stack (WIDTH, DEPTH); ALU datapath inline in alu_lifo.

Verification
REQ-033 Reset: assert i_rst mid-run after pushes 0x1111,0x2222 -> o_s0=o_s1=0, o_data=0 immediately, without a clock edge.
REQ-034 ALU: ADD 0xFFFF+0x0001 -> o_data=0x0000 one cycle later; SUB 0x0000-0x0001 -> 0xFFFF; XOR 0xFFFF^0x1234 -> 0xEDCB; NO_OP arg0=0xBEEF -> 0xBEEF.
REQ-035 Rotate: ROL 0x8001 -> 0x0003; ROR 0x8001 -> 0xC000; code 9 -> 0x0000.
REQ-036 Stack order: push 0x0001, 0x0002, 0x0003 -> o_s0=3, o_s1=2; pop -> o_s0=2, o_s1=1; pop twice more -> o_s0=o_s1=0; extra pop -> still 0.
REQ-037 Replace: stack (0x000A,0x000B), push+pop with i_data=0x00FF -> o_s0=0x00FF, o_s1=0x000B.
REQ-038 Overflow: push DEPTH+1 values 1..13 (DEPTH=12) -> o_s0=13; then 12 pops show 12..2 on o_s0, then o_s0=0 (value 1 lost).
